// File: rtl/counter_pkg.sv
// Shared constants and state encoding for the load-and-countdown counter.
package counter_pkg;

    localparam int WIDTH_DEFAULT = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

endpackage

// File: rtl/counter.sv
// Loadable down-counter: ena loads din, the count runs to zero,
// and oflag pulses for one cycle when it expires.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             ena,
    output logic             oflag
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             oflag_q, oflag_d;

    // Load wins over decrement and expiry; expiry leaves cnt at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        oflag_d = 1'b0;
        if (ena) begin
            cnt_d   = din;
            state_d = COUNT;
        end else if (state_q == COUNT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else begin
                oflag_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            oflag_q <= oflag_d;
        end
    end

    assign oflag = oflag_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for the countdown counter: a per-edge vector table plus
// hand-written sequences for the long count and the mid-count reset.
module tb_counter;
    import counter_pkg::*;

    localparam int WIDTH = 6;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic             ena;
    logic             oflag;

    int checks;
    int errors;

    typedef struct {
        logic             rst_n;
        logic             ena;
        logic [WIDTH-1:0] din;
        logic             exp_oflag;
        string            tag;
    } vec_t;

    vec_t vecs[$];

    counter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .ena   (ena),
        .oflag (oflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs while clk is low, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] d);
        @(negedge clk);
        rst_n = r;
        ena   = e;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic [WIDTH-1:0] d,
                       input logic exp, input string tag);
        vec_t v;
        v.rst_n = r;
        v.ena = e;
        v.din = d;
        v.exp_oflag = exp;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ena   = 1'b0;
        din   = '0;

        // Reset held 3 cycles with ena=1, din=5: reset must win.
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 6'd5, 1'b0, "reset_over_ena");
        add(1'b1, 1'b0, 6'd0, 1'b0, "post_reset_idle");
        add(1'b1, 1'b0, 6'd0, 1'b0, "post_reset_idle");

        // din=8 loaded on 2 edges; pulse on 9th edge after the last load.
        add(1'b1, 1'b1, 6'd8, 1'b0, "load8_a");
        add(1'b1, 1'b1, 6'd8, 1'b0, "load8_b");
        for (int i = 1; i <= 8; i++) add(1'b1, 1'b0, 6'd0, 1'b0, "count8");
        add(1'b1, 1'b0, 6'd0, 1'b1, "pulse8");
        add(1'b1, 1'b0, 6'd0, 1'b0, "after_pulse8");
        add(1'b1, 1'b0, 6'd0, 1'b0, "idle8");

        // din=0: pulse on the very next edge.
        add(1'b1, 1'b1, 6'd0, 1'b0, "load0");
        add(1'b1, 1'b0, 6'd0, 1'b1, "pulse0");
        add(1'b1, 1'b0, 6'd0, 1'b0, "after_pulse0");
        add(1'b1, 1'b0, 6'd0, 1'b0, "idle0");

        // Count 8, reload 16 after 5 edges; the 8-count never pulses.
        add(1'b1, 1'b1, 6'd8, 1'b0, "load8_r");
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 6'd0, 1'b0, "count8_r");
        add(1'b1, 1'b1, 6'd16, 1'b0, "reload16_a");
        add(1'b1, 1'b1, 6'd16, 1'b0, "reload16_b");
        for (int i = 1; i <= 16; i++) add(1'b1, 1'b0, 6'd0, 1'b0, "count16");
        add(1'b1, 1'b0, 6'd0, 1'b1, "pulse16");
        add(1'b1, 1'b0, 6'd0, 1'b0, "after_pulse16");

        // Load arriving on the would-be expiry edge suppresses that pulse.
        add(1'b1, 1'b1, 6'd2, 1'b0, "load2");
        add(1'b1, 1'b0, 6'd0, 1'b0, "count2_a");
        add(1'b1, 1'b0, 6'd0, 1'b0, "count2_b");
        add(1'b1, 1'b1, 6'd1, 1'b0, "load_beats_expiry");
        add(1'b1, 1'b0, 6'd0, 1'b0, "count1");
        add(1'b1, 1'b0, 6'd0, 1'b1, "pulse1");
        add(1'b1, 1'b0, 6'd0, 1'b0, "after_pulse1");

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].ena, vecs[i].din);
            check(vecs[i].tag, {31'd0, oflag}, {31'd0, vecs[i].exp_oflag});
        end

        // Reset state check after a fresh reset.
        step(1'b0, 1'b1, 6'd5);
        check("reset_state", {31'd0, dut.state_q}, {31'd0, IDLE});
        check("reset_cnt", {26'd0, dut.cnt_q}, 32'd0);
        step(1'b1, 1'b0, 6'd0);
        check("idle_after_release", {31'd0, dut.state_q}, {31'd0, IDLE});

        // Max din counts fully: pulse on the 64th edge, no wrap, then stays quiet.
        step(1'b1, 1'b1, 6'd63);
        check("load63_cnt", {26'd0, dut.cnt_q}, 32'd63);
        for (int i = 1; i <= 63; i++) begin
            step(1'b1, 1'b0, 6'd0);
            check("count63", {31'd0, oflag}, 32'd0);
        end
        check("count63_end_cnt", {26'd0, dut.cnt_q}, 32'd0);
        step(1'b1, 1'b0, 6'd0);
        check("pulse63", {31'd0, oflag}, 32'd1);
        check("no_wrap_cnt", {26'd0, dut.cnt_q}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 6'd0);
            check("idle63", {31'd0, oflag}, 32'd0);
        end
        check("idle63_cnt", {26'd0, dut.cnt_q}, 32'd0);

        // din=4, reset on the 2nd count edge: count aborted, no pulse.
        step(1'b1, 1'b1, 6'd4);
        step(1'b1, 1'b0, 6'd0);
        check("abort_cnt_before", {26'd0, dut.cnt_q}, 32'd3);
        step(1'b0, 1'b0, 6'd0);
        check("abort_cnt_reset", {26'd0, dut.cnt_q}, 32'd0);
        check("abort_oflag_reset", {31'd0, oflag}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 6'd0);
            check("abort_no_pulse", {31'd0, oflag}, 32'd0);
        end
        check("abort_cnt_final", {26'd0, dut.cnt_q}, 32'd0);
        check("abort_state_final", {31'd0, dut.state_q}, {31'd0, IDLE});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter: WIDTH, default 6, bit width of load value and internal count.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
REQ-004 Port: din  input  WIDTH  unsigned start value for the countdown, sampled only when ena=1.
REQ-005 Port: ena  input  1  load strobe; level-sampled every rising edge.
REQ-006 Port: oflag  output  1  registered single-cycle pulse, countdown expired.

Function
REQ-007 States SHALL be IDLE and COUNT; internal register cnt[WIDTH-1:0].
REQ-008 Any edge with rst_n=1 and ena=1 SHALL load cnt<=din, enter COUNT and drive oflag<=0, from either state.
REQ-009 Load SHALL have priority over decrement and expiry in the same cycle.
REQ-010 ena held high for several edges SHALL reload din on each edge; countdown starts at the first edge with ena=0.
REQ-011 In COUNT with ena=0 and cnt!=0: cnt<=cnt-1, oflag<=0.
REQ-012 In COUNT with ena=0 and cnt==0: oflag<=1 for exactly one cycle, state<=IDLE, cnt stays 0.
REQ-013 Latency: oflag rises on the (din+1)th rising edge after the last edge sampling ena=1.
REQ-014 din=0: oflag rises on the first edge after the load edge.
REQ-015 In IDLE with ena=0: cnt holds, oflag<=0; no further pulses.
REQ-016 Reload mid-count (ena=1 in COUNT): discards the current count, no oflag for the aborted count, restarts from the new din.
REQ-017 cnt SHALL never wrap below 0; max din (2^WIDTH-1) SHALL count fully.
REQ-018 oflag SHALL be driven directly from a flop, with no combinational path from inputs.

Reset
REQ-019 rst_n=0 at a rising edge: state<=IDLE, cnt<=0, oflag<=0.
REQ-020 Reset SHALL override ena.
REQ-021 Reset asserted mid-count SHALL abort the count with no oflag pulse.
REQ-022 Deasserted rst_n SHALL have no effect until the next edge.

Structure
REQ-023 Shared package counter_pkg SHALL hold the WIDTH default constant and the state enum (IDLE, COUNT).
REQ-024 Single flat module, no sub-modules; one sequential process plus next-state logic.

Verification
REQ-025 rst_n=0 for 3 cycles with ena=1, din=5 -> oflag=0 throughout, state IDLE after release.
REQ-026 din=8, ena=1 for 2 edges then 0 -> oflag is a single-cycle pulse on the 9th edge after the last ena=1 edge.
REQ-027 Count from 8; after 5 edges apply din=16, ena=1 for 2 edges -> no pulse for the 8 count, pulse on the 17th edge after the last ena=1 edge.
REQ-028 din=0, ena=1 for 1 edge -> oflag pulse on the next edge, then 0.
REQ-029 din=63 -> pulse on the 64th edge after load, no wrap; then idle with ena=0 for 10 cycles -> oflag remains 0.
REQ-030 din=4 load, rst_n=0 on the 2nd count edge -> oflag never pulses, cnt=0.
